// File: rtl/gray_decoder_checker.sv
// Gray-to-binary decoder with single-bit step checking, lock FSM and saturating error count.
// Optional macro GRAY_ERR_STICKY_EN turns step_err into a flag held until clear or reset.
module gray_decoder_checker #(
   parameter int WIDTH  = 4,
   parameter int CNT_W  = 8,
   parameter int LOCK_N = 4
) (
   input  logic             SYS_CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             gray_valid,
   input  logic             clear,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_err,
   output logic [CNT_W-1:0] err_count,
   output logic             locked
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [7:0]       LOCK_LIM = 8'(LOCK_N);
   localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] prev_reg, prev_next;
   logic [WIDTH-1:0] bin_reg, bin_next;
   logic [7:0]       good_cnt_reg, good_cnt_next;
   logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
   logic             bin_valid_reg, bin_valid_next;
   logic             step_err_reg, step_err_next;
   logic             illegal_step;
   logic [WIDTH-1:0] bin_conv;
   logic [WIDTH-1:0] step_diff;

   // Each binary bit is the parity of all Gray bits at and above it.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
         assign bin_conv[gi] = ^gray_in[WIDTH-1:gi];
      end
   endgenerate

   assign step_diff = gray_in ^ prev_reg;

   always_ff @(posedge SYS_CLK or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         prev_reg      <= '0;
         bin_reg       <= '0;
         good_cnt_reg  <= '0;
         err_cnt_reg   <= '0;
         bin_valid_reg <= 1'b0;
         step_err_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         prev_reg      <= prev_next;
         bin_reg       <= bin_next;
         good_cnt_reg  <= good_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         bin_valid_reg <= bin_valid_next;
         step_err_reg  <= step_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      prev_next      = prev_reg;
      bin_next       = bin_reg;
      good_cnt_next  = good_cnt_reg;
      err_cnt_next   = err_cnt_reg;
      bin_valid_next = 1'b0;
      illegal_step   = 1'b0;

      if (clear) begin
         state_next    = IDLE;
         good_cnt_next = '0;
         err_cnt_next  = '0;
      end else if (gray_valid) begin
         bin_next       = bin_conv;
         bin_valid_next = 1'b1;
         prev_next      = gray_in;
         case (state_reg)
            IDLE: begin
               state_next    = ACQUIRE;
               good_cnt_next = '0;
            end
            ACQUIRE, LOCKED: begin
               if ($countones(step_diff) > 1) begin
                  illegal_step  = 1'b1;
                  good_cnt_next = '0;
                  state_next    = ACQUIRE;
                  if (err_cnt_reg != ERR_MAX) err_cnt_next = err_cnt_reg + 1'b1;
               end else if ($countones(step_diff) == 1) begin
                  // Reaching the lock threshold locks on this same edge.
                  if (good_cnt_reg >= LOCK_LIM - 8'd1) begin
                     good_cnt_next = LOCK_LIM;
                     state_next    = LOCKED;
                  end else begin
                     good_cnt_next = good_cnt_reg + 8'd1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end

`ifdef GRAY_ERR_STICKY_EN
      step_err_next = clear ? 1'b0 : (step_err_reg | illegal_step);
`else
      step_err_next = illegal_step;
`endif
   end

   assign bin_out   = bin_reg;
   assign bin_valid = bin_valid_reg;
   assign step_err  = step_err_reg;
   assign err_count = err_cnt_reg;
   assign locked    = (state_reg == LOCKED);

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Directed plus random check of gray_decoder_checker against a behavioural model (CNT_W=2 for saturation).
module tb_gray_decoder_checker;
   localparam int WIDTH   = 4;
   localparam int CNT_W   = 2;
   localparam int LOCK_N  = 4;
   localparam int ERR_MAX = 3;

   logic             SYS_CLK = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] gray_in = '0;
   logic             gray_valid = 1'b0;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] bin_out;
   logic             bin_valid;
   logic             step_err;
   logic [CNT_W-1:0] err_count;
   logic             locked;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit       m_have;
   bit [3:0] m_prev;
   int       m_good;
   bit       m_locked;
   int       m_err;
   int       m_bin;
   bit       m_valid;
   bit       m_serr;

   gray_decoder_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
      .SYS_CLK(SYS_CLK), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
      .clear(clear), .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
      .err_count(err_count), .locked(locked)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   function automatic bit [3:0] b2g(input int b);
      bit [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic int g2b(input bit [3:0] g);
      bit [3:0] r;
      r = 4'b0;
      for (int k = 0; k < 4; k++) r = r ^ (g >> k);
      return int'(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_prev = 0; m_good = 0; m_locked = 0;
      m_err = 0; m_bin = 0; m_valid = 0; m_serr = 0;
   endtask

   task automatic model_step(input bit [3:0] g, input bit v, input bit c);
      int d;
      bit illegal;
      illegal = 0;
      if (c) begin
         m_have = 0; m_err = 0; m_locked = 0; m_good = 0; m_valid = 0; m_serr = 0;
      end else if (v) begin
         m_valid = 1;
         m_bin = g2b(g);
         if (m_have) begin
            d = $countones(g ^ m_prev);
            if (d >= 2) begin
               illegal = 1;
               if (m_err < ERR_MAX) m_err++;
               m_good = 0;
               m_locked = 0;
            end else if (d == 1) begin
               if (m_good < LOCK_N) m_good++;
               if (m_good == LOCK_N) m_locked = 1;
            end
         end
         m_have = 1;
         m_prev = g;
`ifdef GRAY_ERR_STICKY_EN
         m_serr = m_serr | illegal;
`else
         m_serr = illegal;
`endif
      end else begin
         m_valid = 0;
`ifndef GRAY_ERR_STICKY_EN
         m_serr = 0;
`endif
      end
   endtask

   task automatic check_all();
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("bin_valid", 32'(bin_valid), 32'(m_valid));
      chk("step_err", 32'(step_err), 32'(m_serr));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("locked", 32'(locked), 32'(m_locked));
   endtask

   task automatic cyc(input bit [3:0] g, input bit v, input bit c);
      @(negedge SYS_CLK);
      gray_in = g; gray_valid = v; clear = c;
      @(posedge SYS_CLK);
      model_step(g, v, c);
      #1 check_all();
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_bin_out"}, 32'(bin_out), 32'd0);
      chk({pfx, "_bin_valid"}, 32'(bin_valid), 32'd0);
      chk({pfx, "_step_err"}, 32'(step_err), 32'd0);
      chk({pfx, "_err_count"}, 32'(err_count), 32'd0);
      chk({pfx, "_locked"}, 32'(locked), 32'd0);
   endtask

   initial begin
      bit [3:0] g;
      int r;
      model_reset();
      repeat (2) @(negedge SYS_CLK);
      check_zero("reset");
      reset = 1'b1;

      // Counting sequence locks after four good steps
      for (int b = 0; b <= 4; b++) begin
         cyc(b2g(b), 1, 0);
         chk("count_bin", 32'(bin_out), 32'(b));
      end
      chk("lock_after_5", 32'(locked), 32'd1);
      chk("lock_err0", 32'(err_count), 32'd0);

      // Illegal d=2 step from 0110 to 0101
      cyc(4'b0101, 1, 0);
      chk("illegal_serr", 32'(step_err), 32'd1);
      chk("illegal_bin", 32'(bin_out), 32'd6);
      chk("illegal_err", 32'(err_count), 32'd1);
      chk("illegal_unlock", 32'(locked), 32'd0);
      for (int b = 7; b <= 10; b++) cyc(b2g(b), 1, 0);
      chk("relock", 32'(locked), 32'd1);

      // Full wrap including 1000 -> 0000
      for (int b = 11; b <= 15; b++) cyc(b2g(b), 1, 0);
      for (int b = 0; b <= 15; b++) cyc(b2g(b), 1, 0);
      cyc(4'b0000, 1, 0);
      chk("wrap_bin", 32'(bin_out), 32'd0);
      chk("wrap_locked", 32'(locked), 32'd1);
      chk("wrap_serr", 32'(step_err), 32'd0);

      // Saturation with CNT_W=2
      cyc(4'b0000, 0, 1);
      for (int i = 0; i < 6; i++) begin
         cyc((i % 2 == 0) ? 4'b0000 : 4'b0011, 1, 0);
         chk("sat_err", 32'(err_count), 32'((i < ERR_MAX) ? i : ERR_MAX));
      end

      // clear together with gray_valid while locked
      cyc(4'b0000, 0, 1);
      for (int b = 0; b <= 4; b++) cyc(b2g(b), 1, 0);
      cyc(4'b0011, 1, 0);
      cyc(b2g(5), 1, 1);
      chk("clr_valid", 32'(bin_valid), 32'd0);
      chk("clr_locked", 32'(locked), 32'd0);
      chk("clr_err", 32'(err_count), 32'd0);
      chk("clr_bin_hold", 32'(bin_out), 32'd2);
      cyc(4'b1111, 1, 0);
      chk("clr_nocheck", 32'(step_err), 32'd0);

      // Async reset asserted between edges
      for (int b = 0; b <= 5; b++) cyc(b2g(b), 1, 0);
      @(negedge SYS_CLK);
      gray_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check_zero("async");
      model_reset();
      @(negedge SYS_CLK);
      reset = 1'b1;
      cyc(4'b1010, 1, 0);
      chk("post_reset_nocheck", 32'(step_err), 32'd0);

      // Random stream: mostly single-bit steps, some repeats, jumps and clears
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55)      g = m_prev ^ (4'b0001 << $urandom_range(0, 3));
         else if (r < 70) g = m_prev;
         else             g = 4'($urandom_range(0, 15));
         cyc(g, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
